// File: rtl/tt_um_prbs10_checker_shivam_if.sv
// rtl/tt_um_prbs10_checker_shivam_if.sv - Tiny Tapeout tile pin bundle for the PRBS10 checker
interface tt_um_prbs10_checker_shivam_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Driver side (off-chip stimulus or the generator tile)
    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    // Checker tile side
    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_prbs10_checker_shivam.sv
// rtl/tt_um_prbs10_checker_shivam.sv - serial PRBS10 checker tile, optional PRBS10_CHK_AUTORESYNC_EN loss-of-lock window
module tt_um_prbs10_checker_shivam (
    input  logic                          clk,
    input  logic                          rst_n,
    tt_um_prbs10_checker_shivam_if.slave  bus
);

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [9:0]  r, r_n;
    logic [3:0]  fill_cnt, fill_n;
    logic [7:0]  err_cnt, err_n;
    logic        err_pulse, pulse_n;
    logic        lol_sticky, lol_n;

`ifdef PRBS10_CHK_AUTORESYNC_EN
    logic [4:0]  win_cnt, win_cnt_n;
    logic [2:0]  win_err, win_err_n;
    logic [2:0]  win_base;
`endif

    logic        rx_bit, rx_valid, clr, resync;
    logic        pred, mismatch, lol_evt;
    logic [9:0]  shifted;

    assign rx_bit   = bus.ui_in[0];
    assign rx_valid = bus.ui_in[1];
    assign clr      = bus.ui_in[2];
    assign resync   = bus.ui_in[3];

    // State register: everything holds unless the tile is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEED;
            r          <= '0;
            fill_cnt   <= '0;
            err_cnt    <= '0;
            err_pulse  <= 1'b0;
            lol_sticky <= 1'b0;
`ifdef PRBS10_CHK_AUTORESYNC_EN
            win_cnt    <= '0;
            win_err    <= '0;
`endif
        end else begin
            state      <= state_n;
            r          <= r_n;
            fill_cnt   <= fill_n;
            err_cnt    <= err_n;
            err_pulse  <= pulse_n;
            lol_sticky <= lol_n;
`ifdef PRBS10_CHK_AUTORESYNC_EN
            win_cnt    <= win_cnt_n;
            win_err    <= win_err_n;
`endif
        end
    end

    // Next-state: seed fill, free-running prediction, error counting, resync/clr overrides
    always_comb begin
        state_n  = state;
        r_n      = r;
        fill_n   = fill_cnt;
        err_n    = err_cnt;
        pulse_n  = err_pulse;
        lol_n    = lol_sticky;
        pred     = r[9] ^ r[8];
        mismatch = 1'b0;
        lol_evt  = 1'b0;
        shifted  = {r[8:0], rx_bit};
`ifdef PRBS10_CHK_AUTORESYNC_EN
        win_cnt_n = win_cnt;
        win_err_n = win_err;
        win_base  = win_err;
`endif
        if (bus.ena) begin
            pulse_n = 1'b0;
            if (resync) begin
                state_n = SEED;
                fill_n  = '0;
`ifdef PRBS10_CHK_AUTORESYNC_EN
                win_cnt_n = '0;
                win_err_n = '0;
`endif
            end else if (rx_valid) begin
                if (state == SEED) begin
                    r_n = shifted;
                    // The tenth seed bit either locks or restarts the fill; the
                    // counter is recycled either way since CHECK never reads it.
                    if (fill_cnt == 4'd9) begin
                        fill_n = '0;
                        if (shifted != 10'd0) begin
                            state_n = CHECK;
                        end
                    end else begin
                        fill_n = fill_cnt + 4'd1;
                    end
                end else begin
                    // Local LFSR free-runs so a single flipped input bit counts once
                    r_n      = {r[8:0], pred};
                    mismatch = rx_bit ^ pred;
                    if (mismatch) begin
                        pulse_n = 1'b1;
                        if (err_cnt != 8'hff) begin
                            err_n = err_cnt + 8'd1;
                        end
                    end
`ifdef PRBS10_CHK_AUTORESYNC_EN
                    // The bit that wraps the window counter opens the new window
                    win_cnt_n = win_cnt + 5'd1;
                    win_base  = (win_cnt == 5'd31) ? 3'd0 : win_err;
                    win_err_n = win_base + {2'b00, mismatch};
                    if (mismatch && (win_base == 3'd3)) begin
                        state_n   = SEED;
                        fill_n    = '0;
                        win_cnt_n = '0;
                        win_err_n = '0;
                        lol_evt   = 1'b1;
                    end
`endif
                end
            end
            if (clr) begin
                err_n = '0;
                lol_n = 1'b0;
            end
            if (lol_evt) begin
                lol_n = 1'b1;
            end
        end
    end

    assign bus.uo_out  = err_cnt;
    assign bus.uio_out = {5'b00000, lol_sticky, err_pulse, (state == CHECK)};
    assign bus.uio_oe  = 8'b0000_0111;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ui_in[7:4], bus.uio_in};

endmodule

// File: tb/tb_tt_um_prbs10_checker_shivam.sv
// tb/tb_tt_um_prbs10_checker_shivam.sv - randomized self-checking bench for the PRBS10 checker tile
`timescale 1ns/1ps
module tb_tt_um_prbs10_checker_shivam;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_um_prbs10_checker_shivam_if bus();

    tt_um_prbs10_checker_shivam dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Generator bit sequence: seq[n] = seq[n-10] ^ seq[n-9], first ten entries are the 10'b1 seed
    int gen [4096];
    int gidx;

    // Reference model of the checker, kept at the bit-sequence level
    int m_locked, m_fill, m_k, m_werr, m_err, m_pulse, m_lol;
    int q[$];

    function automatic void model_reset();
        m_locked = 0; m_fill = 0; m_k = 0; m_werr = 0;
        m_err = 0; m_pulse = 0; m_lol = 0;
        q.delete();
    endfunction

    function automatic void model_edge(int en, int rx, int vld, int c, int rs);
        int p;
        int lol_evt;
        if (en == 0) return;
        lol_evt = 0;
        m_pulse = 0;
        if (rs != 0) begin
            m_locked = 0; m_fill = 0; m_k = 0; m_werr = 0;
            q.delete();
        end else if (vld != 0) begin
            if (m_locked == 0) begin
                q.push_back(rx);
                if (q.size() > 10) void'(q.pop_front());
                m_fill++;
                if (m_fill == 10) begin
                    m_fill = 0;
                    if (q.sum() != 0) begin
                        m_locked = 1; m_k = 0; m_werr = 0;
                    end else begin
                        q.delete();
                    end
                end
            end else begin
                p = q[q.size()-10] ^ q[q.size()-9];
                q.push_back(p);
                void'(q.pop_front());
                if (m_k % 32 == 31) m_werr = 0;
                m_k++;
                if (rx != p) begin
                    m_pulse = 1;
                    if (m_err < 255) m_err++;
                    m_werr++;
`ifdef PRBS10_CHK_AUTORESYNC_EN
                    if (m_werr == 4) begin
                        m_locked = 0; m_fill = 0; m_k = 0; m_werr = 0;
                        q.delete();
                        lol_evt = 1;
                    end
`endif
                end
            end
        end
        if (c != 0) begin
            m_err = 0;
            m_lol = 0;
        end
        if (lol_evt != 0) m_lol = 1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [7:0] want_uio;
        want_uio = {5'b00000, m_lol[0], m_pulse[0], m_locked[0]};
        checks++;
        assert (bus.uo_out === 8'(m_err)) else begin
            errors++;
            $error("FAIL %s err_cnt got %0d want %0d", tag, bus.uo_out, m_err);
        end
        checks++;
        assert (bus.uio_out === want_uio) else begin
            errors++;
            $error("FAIL %s uio_out got %b want %b", tag, bus.uio_out, want_uio);
        end
        checks++;
        assert (bus.uio_oe === 8'h07) else begin
            errors++;
            $error("FAIL %s uio_oe got %h want 07", tag, bus.uio_oe);
        end
    endtask

    task automatic expect_eq(input int got, input int want, input string tag);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step(input logic rx, input logic vld, input logic c, input logic rs,
                        input logic en, input string tag);
        bus.ena    = en;
        bus.ui_in  = {4'($urandom), rs, c, vld, rx};
        bus.uio_in = 8'($urandom);
        model_edge(int'(en), int'(rx), int'(vld), int'(c), int'(rs));
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic sbit(input int inv, input string tag);
        logic b;
        b = logic'(gen[gidx] ^ inv);
        gidx++;
        step(b, 1'b1, 1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        int pulses;
        int keep;
        logic en, vld, c, rx;
        int inv;

        for (int i = 0; i < 10; i++) gen[i] = (i == 9) ? 1 : 0;
        for (int i = 10; i < 4096; i++) gen[i] = gen[i-10] ^ gen[i-9];
        gidx = 10 + 20;

        bus.ena = 1'b0; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean lock on 40 generator bits
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            sbit(0, "clean");
            if (i == 9) expect_eq(int'(bus.uio_out[0]), 1, "locked_after_10");
            pulses += int'(bus.uio_out[1]);
        end
        expect_eq(int'(bus.uo_out), 0, "clean_err_cnt");
        expect_eq(pulses, 0, "clean_no_pulse");

        // Single injected error at bit 15
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            sbit((i == 15) ? 1 : 0, "single");
            pulses += int'(bus.uio_out[1]);
        end
        expect_eq(pulses, 1, "single_pulse_count");
        expect_eq(int'(bus.uo_out), 1, "single_err_cnt");
        expect_eq(int'(bus.uio_out[0]), 1, "single_still_locked");

        // Zero seed refuses to lock, nonzero stream then locks
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "zs_resync");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "zs_zero");
        expect_eq(int'(bus.uio_out[0]), 0, "zero_seed_unlocked");
        for (int i = 0; i < 10; i++) sbit(0, "zs_stream");
        expect_eq(int'(bus.uio_out[0]), 1, "zero_seed_relock");

        // Randomized gaps, enable drops, clears and sparse injected errors
        for (int i = 0; i < 300; i++) begin
            en  = ($urandom_range(0, 99) >= 5);
            vld = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 49) == 0);
            inv = (m_locked != 0 && $urandom_range(0, 39) == 0) ? 1 : 0;
            if (en && vld) begin
                rx = logic'(gen[gidx] ^ inv);
                gidx++;
            end else begin
                rx = 1'($urandom);
            end
            step(rx, vld, c, 1'b0, en, "random");
        end

        // Four errors within one window
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "lol_prep");
        for (int i = 0; i < 10; i++) sbit(0, "lol_seed");
        expect_eq(int'(bus.uio_out[0]), 1, "lol_locked_before");
        for (int i = 0; i < 12; i++) begin
            sbit((i == 2 || i == 5 || i == 8 || i == 11) ? 1 : 0, "lol_err");
        end
        expect_eq(int'(bus.uo_out), 4, "lol_err_cnt");
`ifdef PRBS10_CHK_AUTORESYNC_EN
        expect_eq(int'(bus.uio_out[0]), 0, "lol_unlocked");
        expect_eq(int'(bus.uio_out[2]), 1, "lol_sticky");
        for (int i = 0; i < 10; i++) sbit(0, "lol_relock");
        expect_eq(int'(bus.uio_out[0]), 1, "lol_relocked");
`else
        expect_eq(int'(bus.uio_out[0]), 1, "no_lol_locked");
        expect_eq(int'(bus.uio_out[2]), 0, "no_lol_sticky");
`endif

        // Gating: enable low, then valid low, with toggling inputs
        for (int i = 0; i < 8; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "gate_ena");
        for (int i = 0; i < 8; i++)
            step(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, "gate_valid");
        keep = m_err;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "gate_resync");
        expect_eq(int'(bus.uio_out[0]), 0, "resync_unlocks");
        expect_eq(int'(bus.uo_out), keep, "resync_keeps_err");

`ifndef PRBS10_CHK_AUTORESYNC_EN
        // Saturation and clear coincident with a mismatch
        for (int i = 0; i < 10; i++) sbit(0, "sat_seed");
        for (int i = 0; i < 300; i++) sbit(1, "sat_err");
        expect_eq(int'(bus.uo_out), 255, "saturated");
        rx = logic'(gen[gidx] ^ 1);
        gidx++;
        step(rx, 1'b1, 1'b1, 1'b0, 1'b1, "clr_mismatch");
        expect_eq(int'(bus.uo_out), 0, "clr_wins_err_cnt");
        expect_eq(int'(bus.uio_out[1]), 1, "clr_pulse_fires");
`endif

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) sbit(1, "pre_reset");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) sbit(0, "post_reset");
        expect_eq(int'(bus.uio_out[0]), 1, "post_reset_lock");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_prbs10_checker_shivam.md
# tt_um_prbs10_checker_shivam

Serial PRBS10 checker: the receive end of the team's 10-bit Fibonacci LFSR pattern generator (recurrence: new bit = s[9] XOR s[8], shifted in at the LSB). It seeds a local LFSR from the incoming bit stream, free-runs it to predict each following bit, and counts mismatches. It declares loss of lock when the error density is too high. It is a Tiny Tapeout user tile, driven off-chip or looped back from the generator tile.

## Interface
- No parameters. Constants: LFSR width 10, window 32 bits, loss-of-lock threshold 4 errors per window.
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  tile enable; when low, no bit is sampled and all state holds
- ui_in  input  8  [0] rx_bit, [1] rx_valid, [2] clr (clear counters/sticky), [3] resync (force SEED), [7:4] unused
- uo_out  output  8  error count err_cnt[7:0], saturating
- uio_in  input  8  unused
- uio_out  output  8  [0] locked, [1] err_pulse, [2] lol_sticky, [7:3] = 0
- uio_oe  output  8  constant 8'b0000_0111

## Operation
- Sample event S = ena & rx_valid at a rising edge. Bits are accepted only on S.
- Register r[9:0]: r[0] is the newest bit. Prediction pred = r[9] ^ r[8].
- State SEED (reset state):
  - On S, r <= {r[8:0], rx_bit} and fill_cnt (4 bit) increments.
  - On the S that brings fill_cnt to 10:
    - If the new r != 0, go to CHECK.
    - Else (all-zero lock-up) set fill_cnt = 0 and stay in SEED.
  - No error counting in SEED.
- State CHECK:
  - On S, r <= {r[8:0], pred}. r free-runs and is not reloaded from rx_bit, so one flipped bit counts exactly once.
  - mismatch = rx_bit ^ pred.
  - On mismatch: err_cnt += 1 (saturates at 255), win_err += 1 (3 bit), err_pulse = 1 for the next cycle.
  - win_cnt (5 bit) counts S events in CHECK. When it wraps 31->0, win_err clears; a mismatch on the wrapping bit counts toward the new window as 1.
  - Loss of lock: if win_err would reach 4, go to SEED next. Same edge: fill_cnt = 0, win_cnt = 0, win_err = 0, lol_sticky = 1.
- resync (level, sampled every edge while ena is high): forces SEED with fill_cnt, win_cnt, win_err = 0. err_cnt is not changed and lol_sticky is not set. resync takes priority over S.
- clr (level, while ena is high): err_cnt = 0, lol_sticky = 0. Lock state is unaffected.
  - clr with a simultaneous mismatch: clr wins. err_cnt ends at 0, but err_pulse still fires.
  - clr with a simultaneous loss of lock: lol_sticky ends at 1 (the event wins).
- locked = (state == CHECK).

## Timing
- Reset values: uo_out = 0, uio_out = 0, state SEED, r = 0, all counters 0. uio_oe = 0x07 always.
- All outputs are registered; no combinational path from ui_in to any output.
- locked rises at the edge that samples the 10th valid seed bit. The first checked bit is the next S.
- err_cnt and err_pulse update at the edge sampling the mismatched bit. err_pulse lasts exactly one cycle unless the next cycle also mismatches.
- locked falls at the edge sampling the 4th in-window error, or at the first edge with resync high.
- rx_valid may be held high for back-to-back bits, one bit per cycle. Gaps are allowed and do not advance anything.
- Asserting rst_n low mid-operation clears everything immediately. Operation restarts in SEED on the first edge after release.

## Configuration
- PRBS10_CHK_AUTORESYNC_EN
  - Defined: the loss-of-lock rule above is active.
  - Undefined: the window logic is removed. CHECK persists until rst_n or resync, and lol_sticky stays 0.
  - Error counting and err_pulse are identical in both builds.

## Test plan
- Clean lock: after reset, feed 40 consecutive bits of generator output (generator reset to 10'b1, skip its first 20 output bits). Required: locked = 1 after the 10th bit, err_cnt = 0, err_pulse never high.
- Single injected error: locked stream, invert bit 15 only. Required: exactly one err_pulse, err_cnt = 1, locked stays 1.
- Zero seed: feed 10 zero bits, then 10 valid nonzero stream bits. Required: locked = 0 after the first 10 bits, and locked = 1 after bit 20.
- Loss of lock (macro defined): locked, invert 4 bits within one 32-bit window. Required: err_cnt = 4, locked = 0, lol_sticky = 1 at the 4th error; re-lock after 10 more valid bits. Macro undefined: locked remains 1.
- Saturation and clear: 300 mismatches with the macro undefined. Required: err_cnt = 255. Then clr coincident with a mismatch. Required: err_cnt = 0 and err_pulse = 1.
- Gating: ena = 0 or rx_valid = 0 with toggling rx_bit. Required: no state or output change. resync high. Required: locked = 0 next edge, err_cnt unchanged.
